// File: rtl/uart_setare_timp.sv
// 8N1 UART receiver plus "T HH:MM CR" command parser; drives the counter's
// serial load path with a one-cycle load strobe and range-checked hours/minutes.
module uart_setare_timp #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [4:0] ore,
  output logic [5:0] minute,
  output logic       load,
  output logic       eroare
);

  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;

  typedef enum logic [1:0] {INACTIV, START, DATE, STOP} bit_st_t;
  typedef enum logic [2:0] {AST_T, H1, H2, SEP, M1, M2, CR} parse_st_t;

  logic            rx_m_q, rx_s_q;
  bit_st_t         bst_q, bst_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bidx_q, bidx_d;
  logic [7:0]      sh_q, sh_d;
  parse_st_t       pst_q, pst_d;
  logic [3:0]      h1_q, h1_d, h2_q, h2_d, m1_q, m1_d, m2_q, m2_d;
  logic [4:0]      ore_q, ore_d;
  logic [5:0]      min_q, min_d;
  logic            load_q, load_d, err_q, err_d;

  logic            byte_rdy, stop_ok, match;
  logic [3:0]      digit;
  logic [4:0]      hours;
  logic [5:0]      minutes;

  // Bit-level receiver
  always_comb begin
    bst_d    = bst_q;
    cnt_d    = cnt_q;
    bidx_d   = bidx_q;
    sh_d     = sh_q;
    byte_rdy = 1'b0;
    stop_ok  = 1'b0;
    unique case (bst_q)
      INACTIV: begin
        if (!rx_s_q) begin
          bst_d = START;
          cnt_d = '0;
        end
      end
      START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d  = '0;
          bidx_d = '0;
          bst_d  = rx_s_q ? INACTIV : DATE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATE: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          sh_d  = {rx_s_q, sh_q[7:1]};
          if (bidx_q == 3'd7) bst_d = STOP;
          else                bidx_d = bidx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          byte_rdy = 1'b1;
          stop_ok  = rx_s_q;
          cnt_d    = '0;
          bst_d    = INACTIV;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: bst_d = INACTIV;
    endcase
  end

  // ASCII digits 0x30-0x39 carry their value in the low nibble
  assign digit   = sh_q[3:0];
  assign hours   = 5'(h1_q) * 5'd10 + 5'(h2_q);
  assign minutes = 6'(m1_q) * 6'd10 + 6'(m2_q);

  always_comb begin
    unique case (pst_q)
      AST_T:   match = (sh_q == 8'h54);
      H1:      match = (sh_q >= 8'h30) && (sh_q <= 8'h32);
      H2:      match = (sh_q >= 8'h30) && (sh_q <= 8'h39);
      SEP:     match = (sh_q == 8'h3A);
      M1:      match = (sh_q >= 8'h30) && (sh_q <= 8'h35);
      M2:      match = (sh_q >= 8'h30) && (sh_q <= 8'h39);
      CR:      match = (sh_q == 8'h0D);
      default: match = 1'b0;
    endcase
  end

  // Command parser; consumes the byte on the stop-bit sample edge so the
  // registered strobes appear in the following cycle.
  always_comb begin
    pst_d  = pst_q;
    h1_d   = h1_q;
    h2_d   = h2_q;
    m1_d   = m1_q;
    m2_d   = m2_q;
    ore_d  = ore_q;
    min_d  = min_q;
    load_d = 1'b0;
    err_d  = 1'b0;
    if (byte_rdy) begin
      if (!stop_ok) begin
        err_d = 1'b1;
        pst_d = AST_T;
      end else if (match) begin
        unique case (pst_q)
          AST_T: pst_d = H1;
          H1:    begin h1_d = digit; pst_d = H2;  end
          H2:    begin h2_d = digit; pst_d = SEP; end
          SEP:   pst_d = M1;
          M1:    begin m1_d = digit; pst_d = M2;  end
          M2:    begin m2_d = digit; pst_d = CR;  end
          CR: begin
            if (hours <= 5'd23) begin
              ore_d  = hours;
              min_d  = minutes;
              load_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            pst_d = AST_T;
          end
          default: pst_d = AST_T;
        endcase
      end else if (pst_q != AST_T) begin
        err_d = 1'b1;
        pst_d = (sh_q == 8'h54) ? H1 : AST_T;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      bst_q  <= INACTIV;
      cnt_q  <= '0;
      bidx_q <= '0;
      sh_q   <= '0;
      pst_q  <= AST_T;
      h1_q   <= '0;
      h2_q   <= '0;
      m1_q   <= '0;
      m2_q   <= '0;
      ore_q  <= '0;
      min_q  <= '0;
      load_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;
      bst_q  <= bst_d;
      cnt_q  <= cnt_d;
      bidx_q <= bidx_d;
      sh_q   <= sh_d;
      pst_q  <= pst_d;
      h1_q   <= h1_d;
      h2_q   <= h2_d;
      m1_q   <= m1_d;
      m2_q   <= m2_d;
      ore_q  <= ore_d;
      min_q  <= min_d;
      load_q <= load_d;
      err_q  <= err_d;
    end
  end

  assign ore    = ore_q;
  assign minute = min_q;
  assign load   = load_q;
  assign eroare = err_q;

endmodule

// File: tb/tb_uart_setare_timp.sv
// Bench for uart_setare_timp: directed command sequences plus randomized
// commands, checked per byte against a table-driven command model.
module tb_uart_setare_timp;

  localparam int unsigned CPB = 16;
  localparam int EV_ERR = 131072;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic [4:0] ore;
  logic [5:0] minute;
  logic       load;
  logic       eroare;

  always #5 clock = ~clock;

  uart_setare_timp #(.CLKS_PER_BIT(CPB)) dut (
    .clock  (clock),
    .reset  (reset),
    .rx     (rx),
    .ore    (ore),
    .minute (minute),
    .load   (load),
    .eroare (eroare)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ev_load(input int h, input int m);
    return 65536 + h * 256 + m;
  endfunction

  // Observed strobes, recorded away from the active edge
  int         act_q[$];
  int         both_cnt = 0;
  int         hold_viol = 0;
  logic [4:0] prev_ore = '0;
  logic [5:0] prev_min = '0;

  always @(negedge clock) begin
    if (reset === 1'b0) begin
      if (load && eroare) both_cnt++;
      if (load) act_q.push_back(ev_load(int'(ore), int'(minute)));
      if (eroare) act_q.push_back(EV_ERR);
      if (!load && (ore !== prev_ore || minute !== prev_min)) hold_viol++;
    end
    prev_ore = ore;
    prev_min = minute;
  end

  // Reference model: allowed byte range per command position
  logic [7:0] lo [7] = '{8'h54, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h0D};
  logic [7:0] hi [7] = '{8'h54, 8'h32, 8'h39, 8'h3A, 8'h35, 8'h39, 8'h0D};
  int m_pos = 0;
  int m_d [7];
  int m_ore = 0;
  int m_min = 0;
  int exp_q[$];

  task automatic model_byte(input logic [7:0] b, input bit ok);
    int h, mn;
    if (!ok) begin
      exp_q.push_back(EV_ERR);
      m_pos = 0;
    end else if (b >= lo[m_pos] && b <= hi[m_pos]) begin
      m_d[m_pos] = int'(b) - 48;
      if (m_pos == 6) begin
        h  = 10 * m_d[1] + m_d[2];
        mn = 10 * m_d[4] + m_d[5];
        if (h <= 23) begin
          exp_q.push_back(ev_load(h, mn));
          m_ore = h;
          m_min = mn;
        end else begin
          exp_q.push_back(EV_ERR);
        end
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end else if (m_pos != 0) begin
      exp_q.push_back(EV_ERR);
      m_pos = (b == 8'h54) ? 1 : 0;
    end
  endtask

  // Called at a negedge; frames are contiguous when called back-to-back
  task automatic send_frame(input logic [7:0] b, input bit ok);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = ok;
    repeat (CPB) @(negedge clock);
    if (!ok) begin
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clock);
    end
  endtask

  task automatic compare_events(input string tag);
    int n;
    check_eq({tag, " events"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq({tag, " event"}, act_q[i], exp_q[i]);
    check_eq({tag, " ore"}, ore, m_ore);
    check_eq({tag, " minute"}, minute, m_min);
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic send_byte_chk(input logic [7:0] b, input bit ok, input string tag);
    send_frame(b, ok);
    model_byte(b, ok);
    compare_events(tag);
  endtask

  task automatic send_str(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) send_byte_chk(s[i], 1'b1, tag);
  endtask

  task automatic model_reset();
    m_pos = 0;
    m_ore = 0;
    m_min = 0;
    act_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int errs, loads, kind, h, mn, pos;
    logic [7:0] junk;
    string s;

    reset = 1'b1;
    rx    = 1'b1;
    repeat (4) @(negedge clock);
    check_eq("reset ore", ore, 0);
    check_eq("reset minute", minute, 0);
    check_eq("reset load", load, 0);
    check_eq("reset eroare", eroare, 0);
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clock);

    send_str("T13:45\r", "t1345");
    check_eq("t1345 final ore", ore, 13);
    check_eq("t1345 final minute", minute, 45);

    send_str("T23:59\r", "t2359");
    check_eq("t2359 final ore", ore, 23);
    send_str("T00:00\r", "t0000");
    check_eq("t0000 final minute", minute, 0);

    send_str("T25:10\r", "range");
    send_str("T1T08:30\r", "resync");
    check_eq("resync final ore", ore, 8);

    send_byte_chk(8'h54, 1'b0, "framing");
    send_str("T07:05\r", "after framing");
    check_eq("after framing ore", ore, 7);

    rx = 1'b0;
    repeat (3) @(negedge clock);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    check_eq("glitch events", act_q.size(), 0);

    // Break: line held low for 35 bit times
    rx = 1'b0;
    repeat (35 * CPB) @(negedge clock);
    rx = 1'b1;
    repeat (12 * CPB) @(negedge clock);
    errs = 0;
    loads = 0;
    foreach (act_q[i]) begin
      if (act_q[i] == EV_ERR) errs++;
      else loads++;
    end
    act_q.delete();
    check_eq("break loads", loads, 0);
    check_eq("break errors in 3..4", (errs >= 3 && errs <= 4), 1);
    check_eq("break ore", ore, m_ore);
    m_pos = 0;

    // Reset mid-command and mid-byte
    send_str("T12", "pre-reset");
    rx = 1'b0;
    repeat (5 * CPB) @(negedge clock);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    model_reset();
    send_str(":34\r", "post-reset");
    check_eq("post-reset ore", ore, 0);
    check_eq("post-reset minute", minute, 0);
    check_eq("post-reset load", load, 0);

    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 3);
      h    = (kind == 1) ? $urandom_range(24, 29) : $urandom_range(0, 23);
      mn   = $urandom_range(0, 59);
      s    = $sformatf("T%02d:%02d\r", h, mn);
      pos  = $urandom_range(1, 6);
      junk = 8'($urandom_range(32, 126));
      for (int i = 0; i < s.len(); i++) begin
        if (kind == 2 && i == pos) send_byte_chk(junk, 1'b1, "rand junk");
        if (kind == 3 && i == pos) send_byte_chk(junk, 1'b0, "rand framing");
        send_byte_chk(s[i], 1'b1, "rand");
      end
    end

    check_eq("load and eroare together", both_cnt, 0);
    check_eq("outputs changed without load", hold_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
